// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the 32-bit integer ALU. It decodes RV32I OP/OP-IMM,
// reads operands from a 32x32 register file with writeback bypass, tracks pending
// writebacks in a busy scoreboard, and holds the issued bundle in an output register.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  op,
  output logic [31:0] rv1,
  output logic [31:0] rv2,
  output logic [4:0]  rd,
  output logic        out_we,
  output logic        illegal
);

  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcOp    = 7'b0110011;

  logic [31:0] rf_q [32];
  logic [31:0] busy_q, busy_d;

  logic        valid_q;
  logic [5:0]  op_q;
  logic [31:0] rv1_q, rv2_q;
  logic [4:0]  rd_q;
  logic        we_q, ill_q;

  logic [4:0]  rs1, rs2, dst;
  logic        is_op, is_imm, legal, dec_we;
  logic [5:0]  dec_op;
  logic [31:0] dec_rv1, dec_rv2, imm;
  logic [31:0] wb_onehot, eb, set_vec;
  logic        hazard, accept;

  // Register read with same-cycle writeback bypass; x0 always reads zero.
  function automatic logic [31:0] rf_read(input logic [4:0] r, input logic [31:0] v,
                                          input logic en, input logic [4:0] wr,
                                          input logic [31:0] wd);
    logic [31:0] res;
    res = v;
    if (r == 5'd0) res = 32'd0;
    else if (en && wr == r) res = wd;
    return res;
  endfunction

  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign dst = instr[11:7];
  assign imm = {{20{instr[31]}}, instr[31:20]};

  // Decode, operand selection and hazard detection.
  always_comb begin
    is_op   = (instr[6:0] == OpcOp);
    is_imm  = (instr[6:0] == OpcOpImm);
    legal   = is_op || is_imm;
    dec_op  = 6'b000000;
    if (legal) dec_op = {instr[30], instr[14:12], instr[5], 1'b1};
    dec_we  = legal && (dst != 5'd0);
    dec_rv1 = rf_read(rs1, rf_q[rs1], wb_en, wb_rd, wb_data);
    dec_rv2 = is_op ? rf_read(rs2, rf_q[rs2], wb_en, wb_rd, wb_data) : imm;

    wb_onehot = wb_en ? (32'd1 << wb_rd) : 32'd0;
    eb        = busy_q & ~wb_onehot;
    hazard    = (legal && eb[rs1]) || (is_op && eb[rs2]) || (dec_we && eb[dst]);

    in_ready = (!valid_q || out_ready) && !(in_valid && hazard);
    accept   = in_valid && in_ready;
  end

  // Scoreboard next state: set on accepted writing bundle, clear on writeback, set wins.
  always_comb begin
    set_vec   = (accept && dec_we) ? (32'd1 << dst) : 32'd0;
    busy_d    = (busy_q & ~wb_onehot) | set_vec;
    busy_d[0] = 1'b0;
  end

  // Register file: written at the clock edge, x0 never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (wb_en && wb_rd != 5'd0) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= 32'd0;
    else        busy_q <= busy_d;
  end

  // Output bundle register: load on accept, drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= 6'd0;
      rv1_q   <= 32'd0;
      rv2_q   <= 32'd0;
      rd_q    <= 5'd0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      op_q    <= dec_op;
      rv1_q   <= dec_rv1;
      rv2_q   <= dec_rv2;
      rd_q    <= dst;
      we_q    <= dec_we;
      ill_q   <= !legal;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign op        = op_q;
  assign rv1       = rv1_q;
  assign rv2       = rv2_q;
  assign rd        = rd_q;
  assign out_we    = we_q;
  assign illegal   = ill_q;

endmodule
